// File: rtl/modaddsub_pipe_pkg.sv
// Shared constants for the modular add/sub unit:
// modulus table, op encodings and modulus select codes.
package modaddsub_pipe_pkg;

  localparam int QW = 39;

  localparam logic [QW-1:0] Q0 = 39'h07_FFFE_C001;
  localparam logic [QW-1:0] Q1 = 39'h1F_FFFD_8001;
  localparam logic [QW-1:0] Q2 = 39'h7F_FFFF_C001;

  typedef enum logic [1:0] {
    OP_SUB  = 2'b00,
    OP_ADD  = 2'b01,
    OP_NEG  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  localparam logic [1:0] QSEL_Q0  = 2'd0;
  localparam logic [1:0] QSEL_Q1  = 2'd1;
  localparam logic [1:0] QSEL_Q2  = 2'd2;
  localparam logic [1:0] QSEL_RSV = 2'd3;

  // Reserved select yields Q=0, so every operand reads as out of range.
  function automatic logic [QW-1:0] q_of(input logic [1:0] qsel);
    logic [QW-1:0] q;
    q = '0;
    unique case (qsel)
      QSEL_Q0: q = Q0;
      QSEL_Q1: q = Q1;
      QSEL_Q2: q = Q2;
      default: q = '0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/modaddsub_pipe_lane.sv
// One lane: stage-1 raw sums/differences and
// stage-2 modular correction registers.
module modaddsub_lane
  import modaddsub_pipe_pkg::*;
#(
  parameter int W = 39
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en1,
  input  logic         en2,
  input  op_e          op,
  input  logic [W-1:0] q,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         err
);

  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W-1:0] neg;
  logic         bad;

  op_e          op1;
  logic [W-1:0] q1;
  logic [W:0]   s1;
  logic [W:0]   d1;
  logic [W-1:0] n1;
  logic [W-1:0] a1;
  logic         bz1;
  logic         e1;

  logic [W:0]   fix;
  logic [W-1:0] r2;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign neg  = q - b;
  assign bad  = (a >= q) | ((op != OP_PASS) & (b >= q));

  always_ff @(posedge clk) begin
    if (rst) begin
      op1 <= OP_SUB;
      q1  <= '0;
      s1  <= '0;
      d1  <= '0;
      n1  <= '0;
      a1  <= '0;
      bz1 <= 1'b0;
      e1  <= 1'b0;
    end else if (en1) begin
      op1 <= op;
      q1  <= q;
      s1  <= sum;
      d1  <= diff;
      n1  <= neg;
      a1  <= a;
      bz1 <= (b == '0);
      e1  <= bad;
    end
  end

  always_comb begin
    fix = s1 - {1'b0, q1};
    r2  = a1;
    unique case (1'b1)
      op1 == OP_ADD:
        r2 = (s1 >= {1'b0, q1}) ? fix[W-1:0] : s1[W-1:0];
      op1 == OP_SUB:
        r2 = d1[W] ? d1[W-1:0] + q1 : d1[W-1:0];
      op1 == OP_NEG:
        r2 = bz1 ? '0 : n1;
      default:
        r2 = a1;
    endcase
    if (e1) r2 = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
      err <= 1'b0;
    end else if (en2) begin
      res <= r2;
      err <= e1;
    end
  end

endmodule

// File: rtl/modaddsub_pipe.sv
// Multi-lane two-stage modular add/sub/neg/pass unit
// with valid/ready handshake on both sides.
module modaddsub_pipe
  import modaddsub_pipe_pkg::*;
#(
  parameter int COE_WIDTH = 39,
  parameter int LANES     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [1:0]                 i_op,
  input  logic [1:0]                 i_qsel,
  input  logic [LANES*COE_WIDTH-1:0] i_a,
  input  logic [LANES*COE_WIDTH-1:0] i_b,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [LANES*COE_WIDTH-1:0] o_res,
  output logic [LANES-1:0]           o_err
);

  logic                 v1;
  logic                 v2;
  logic                 ld1;
  logic                 ld2;
  logic                 en1;
  logic                 en2;
  logic [COE_WIDTH-1:0] q;
  op_e                  op;

  assign ld2     = !v2 | i_ready;
  assign ld1     = !v1 | ld2;
  assign o_ready = ld1;
  assign o_valid = v2;
  assign en1     = ld1 & i_valid;
  assign en2     = ld2 & v1;
  assign op      = op_e'(i_op);

  always_comb begin
    q         = '0;
    q[QW-1:0] = q_of(i_qsel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (ld1) v1 <= i_valid;
      if (ld2) v2 <= v1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    modaddsub_lane #(
      .W(COE_WIDTH)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .en1(en1),
      .en2(en2),
      .op (op),
      .q  (q),
      .a  (i_a[k*COE_WIDTH +: COE_WIDTH]),
      .b  (i_b[k*COE_WIDTH +: COE_WIDTH]),
      .res(o_res[k*COE_WIDTH +: COE_WIDTH]),
      .err(o_err[k])
    );
  end

endmodule

// File: tb/tb_modaddsub_pipe.sv
// Scoreboard bench for modaddsub_pipe: directed wraps,
// range errors, backpressure, random stream, mid-stream reset.
module tb_modaddsub_pipe;

  localparam int W = 39;
  localparam int L = 4;
  localparam logic [63:0] TQ0 = 64'h07_FFFE_C001;
  localparam logic [63:0] TQ1 = 64'h1F_FFFD_8001;
  localparam logic [63:0] TQ2 = 64'h7F_FFFF_C001;

  typedef struct {
    logic [1:0]     op;
    logic [1:0]     qsel;
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
  } stim_t;

  typedef struct {
    logic [L*W-1:0] res;
    logic [L-1:0]   err;
    int             acc;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           i_valid;
  logic           o_ready;
  logic [1:0]     i_op;
  logic [1:0]     i_qsel;
  logic [L*W-1:0] i_a;
  logic [L*W-1:0] i_b;
  logic           o_valid;
  logic           i_ready;
  logic [L*W-1:0] o_res;
  logic [L-1:0]   o_err;

  stim_t stim_q[$];
  exp_t  sb[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    cyc    = 0;
  bit    took   = 0;
  bit    chk_lat = 1;

  modaddsub_pipe #(
    .COE_WIDTH(W),
    .LANES    (L)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_op   (i_op),
    .i_qsel (i_qsel),
    .i_a    (i_a),
    .i_b    (i_b),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_res  (o_res),
    .o_err  (o_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [L*W-1:0] got,
                     input logic [L*W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] qof(input logic [1:0] qsel);
    case (qsel)
      2'd0:    return TQ0;
      2'd1:    return TQ1;
      2'd2:    return TQ2;
      default: return 64'd0;
    endcase
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [63:0] q, a, b, r;
    bit bad;
    q = qof(s.qsel);
    e.res = '0;
    e.err = '0;
    e.acc = 0;
    for (int k = 0; k < L; k++) begin
      a = 64'(s.a[k*W +: W]);
      b = 64'(s.b[k*W +: W]);
      bad = (s.qsel == 2'd3) || (a >= q) || (s.op != 2'd3 && b >= q);
      r = 64'd0;
      if (!bad) begin
        case (s.op)
          2'd0:    r = (a + q - b) % q;
          2'd1:    r = (a + b) % q;
          2'd2:    r = (q - b) % q;
          default: r = a;
        endcase
      end
      e.err[k] = bad;
      e.res[k*W +: W] = r[W-1:0];
    end
    return e;
  endfunction

  function automatic stim_t mk(input logic [1:0] op, input logic [1:0] qsel,
                               input logic [63:0] a0, input logic [63:0] b0,
                               input logic [63:0] a1, input logic [63:0] b1,
                               input logic [63:0] a2, input logic [63:0] b2,
                               input logic [63:0] a3, input logic [63:0] b3);
    stim_t s;
    s.op   = op;
    s.qsel = qsel;
    s.a    = {a3[W-1:0], a2[W-1:0], a1[W-1:0], a0[W-1:0]};
    s.b    = {b3[W-1:0], b2[W-1:0], b1[W-1:0], b0[W-1:0]};
    return s;
  endfunction

  function automatic logic [63:0] rnd_opnd(input logic [63:0] q);
    logic [63:0] r;
    r = {$urandom, $urandom};
    if (q == 0) return {25'd0, r[W-1:0]};
    if ($urandom_range(0, 15) == 0) return q + 64'($urandom_range(0, 3));
    return r % q;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    logic [63:0] q, x, y;
    s.op   = 2'($urandom_range(0, 3));
    s.qsel = 2'($urandom_range(0, 3));
    q = qof(s.qsel);
    for (int k = 0; k < L; k++) begin
      x = rnd_opnd(q);
      y = rnd_opnd(q);
      s.a[k*W +: W] = x[W-1:0];
      s.b[k*W +: W] = y[W-1:0];
    end
    return s;
  endfunction

  // Driver: presents the head of stim_q until it is taken.
  initial begin
    i_valid = 0;
    i_op    = 0;
    i_qsel  = 0;
    i_a     = '0;
    i_b     = '0;
    forever begin
      @(posedge clk);
      #1;
      if (took && stim_q.size() > 0) void'(stim_q.pop_front());
      if (stim_q.size() > 0) begin
        i_valid = 1;
        i_op    = stim_q[0].op;
        i_qsel  = stim_q[0].qsel;
        i_a     = stim_q[0].a;
        i_b     = stim_q[0].b;
      end else begin
        i_valid = 0;
        i_op    = 2'($urandom);
        i_qsel  = 2'($urandom);
      end
    end
  end

  // Monitor and scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      took = 0;
    end else begin
      chk("o_ready", o_ready, (sb.size() < 2) || i_ready);
      chk("o_valid", o_valid, sb.size() > 0 && cyc - sb[0].acc >= 2);
      if (o_valid && sb.size() > 0) begin
        chk("o_res", o_res, sb[0].res);
        chk("o_err", o_err, sb[0].err);
        if (i_ready) begin
          if (chk_lat) chk("latency", cyc - sb[0].acc, 2);
          void'(sb.pop_front());
        end
      end
      took = i_valid && o_ready;
      if (took && stim_q.size() > 0) begin
        e = model(stim_q[0]);
        e.acc = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int c = 0;
    while ((stim_q.size() > 0 || sb.size() > 0) && c < budget) begin
      step();
      c++;
    end
    chk(tag, stim_q.size() + sb.size(), 0);
  endtask

  initial begin
    int c;
    rst = 1;
    i_ready = 1;
    repeat (3) step();
    rst = 0;
    @(negedge clk);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_res", o_res, 0);
    chk("rst_o_err", o_err, 0);
    chk("rst_o_ready", o_ready, 1);

    chk_lat = 1;
    stim_q.push_back(mk(2'd0, 2'd0, 5, 7, 7, 5, 0, TQ0-1, TQ0-1, TQ0-1));
    stim_q.push_back(mk(2'd1, 2'd2, TQ2-1, 3, TQ2-1, 0, 0, 0, TQ2-1, TQ2-1));
    stim_q.push_back(mk(2'd2, 2'd1, 9, 0, 0, 1, 0, TQ1-1, TQ1-1, TQ1));
    stim_q.push_back(mk(2'd3, 2'd0, TQ0-1, TQ0, 0, TQ2, 123, 0, TQ0, 0));
    stim_q.push_back(mk(2'd1, 2'd1, 10, 20, TQ1, 1, 1, 2, TQ1-1, 1));
    stim_q.push_back(mk(2'd0, 2'd3, 1, 2, 3, 4, 5, 6, 7, 8));
    stim_q.push_back(mk(2'd0, 2'd2, 0, 1, TQ2-1, 0, 1, TQ2-1, 4, 4));
    drain("drain_directed", 40);

    chk_lat = 0;
    for (int i = 0; i < 10; i++) stim_q.push_back(rnd_stim());
    for (int k = 0; k < 16; k++) begin
      i_ready = !(k >= 3 && k <= 7);
      step();
    end
    i_ready = 1;
    drain("drain_backpressure", 60);

    chk_lat = 1;
    for (int i = 0; i < 100; i++) stim_q.push_back(rnd_stim());
    drain("drain_stream", 200);

    i_ready = 0;
    stim_q.push_back(rnd_stim());
    stim_q.push_back(rnd_stim());
    c = 0;
    while (sb.size() < 2 && c < 10) begin
      step();
      c++;
    end
    chk("inflight", sb.size(), 2);
    rst = 1;
    i_ready = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_o_res", o_res, 0);
    chk("midrst_o_ready", o_ready, 1);
    step();
    stim_q.push_back(mk(2'd0, 2'd0, 5, 7, 1, 1, 2, 1, 0, 3));
    drain("drain_after_rst", 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
